// File: rtl/dehaze_window_3x3_pkg.sv
// Shared constants and FSM state type for the 3x3 dehaze window generator.
package dehaze_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = PIX_W * WIN_TAPS;
  localparam int RGB_W    = 3 * PIX_W;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/dehaze_window_3x3_if.sv
// Pixel-in / window-out bundle between the raster source and the 3x3 window generator.
interface dehaze_window_3x3_if;
  logic                         in_valid;
  logic                         in_sof;
  logic [dehaze_pkg::PIX_W-1:0] in_r;
  logic [dehaze_pkg::PIX_W-1:0] in_g;
  logic [dehaze_pkg::PIX_W-1:0] in_b;
  logic                         win_valid;
  logic [dehaze_pkg::WIN_W-1:0] win_r;
  logic [dehaze_pkg::WIN_W-1:0] win_g;
  logic [dehaze_pkg::WIN_W-1:0] win_b;
  logic                         win_last;
  logic                         frame_done;

  modport master (
    output in_valid, in_sof, in_r, in_g, in_b,
    input  win_valid, win_r, win_g, win_b, win_last, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b,
    output win_valid, win_r, win_g, win_b, win_last, frame_done
  );
endinterface

// File: rtl/dehaze_window_3x3_line_buffer.sv
// One line of RGB pixels; registered read-before-write at a single address.
module dehaze_line_buffer
  import dehaze_pkg::*;
#(
  parameter int DEPTH = 320,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [RGB_W-1:0] i_din,
  output logic [RGB_W-1:0] o_dout
);

  logic [RGB_W-1:0] r_mem [DEPTH];
  logic [RGB_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_dout <= r_mem[i_addr];
      if (i_we) begin
        r_mem[i_addr] <= i_din;
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/dehaze_window_3x3.sv
// Raster-to-3x3 window generator feeding the atmospheric-light stage.
// Optional macro DEHAZE_WIN_OUT_REG_EN adds one output register stage.
module dehaze_window_3x3
  import dehaze_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic                clk,
  input  logic                rst,
  dehaze_window_3x3_if.slave  bus
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  state_t           r_state, w_state_next;
  logic [XW-1:0]    r_x, w_x_next, w_x_cur;
  logic [YW-1:0]    r_y, w_y_next, w_y_cur;
  logic             w_accept, w_last_px, w_emit;
  logic [RGB_W-1:0] w_pix_in, r_pix;
  logic [RGB_W-1:0] w_lb_dout [2];
  logic             r_wr_sel;
  logic [RGB_W-1:0] r_c0 [3];
  logic [RGB_W-1:0] r_c1 [3];
  logic [RGB_W-1:0] w_c2 [3];
  logic [RGB_W-1:0] w_tap [WIN_TAPS];
  logic [WIN_W-1:0] w_pack_r, w_pack_g, w_pack_b;
  logic [WIN_W-1:0] r_hold_r, r_hold_g, r_hold_b;
  logic [WIN_W-1:0] w_win_r, w_win_g, w_win_b;
  logic             r_win_valid, r_win_last, r_frame_done;

  assign w_pix_in = {bus.in_r, bus.in_g, bus.in_b};

  // in_sof is honoured in either state and forces the accepted pixel to (0,0).
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_x_cur      = r_x;
    w_y_cur      = r_y;
    w_accept     = 1'b0;
    if (bus.in_valid && bus.in_sof) begin
      w_accept = 1'b1;
      w_x_cur  = '0;
      w_y_cur  = '0;
    end else if (bus.in_valid && (r_state == ST_ACTIVE)) begin
      w_accept = 1'b1;
    end
    w_last_px = (w_x_cur == X_LAST) && (w_y_cur == Y_LAST);
    w_emit    = w_accept && (w_x_cur >= X_TWO) && (w_y_cur >= Y_TWO);
    if (w_accept) begin
      if (w_last_px) begin
        w_state_next = ST_IDLE;
        w_x_next     = '0;
        w_y_next     = '0;
      end else begin
        w_state_next = ST_ACTIVE;
        if (w_x_cur == X_LAST) begin
          w_x_next = '0;
          w_y_next = w_y_cur + YW'(1);
        end else begin
          w_x_next = w_x_cur + XW'(1);
          w_y_next = w_y_cur;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
    end
  end

  // Ping-pong by line parity: the buffer written this line still holds line y-2,
  // the other one holds line y-1, both read at the current column.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_lb
    dehaze_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .AW    (XW)
    ) u_lb (
      .clk    (clk),
      .i_en   (w_accept),
      .i_we   (w_accept && (w_y_cur[0] == 1'(gi))),
      .i_addr (w_x_cur),
      .i_din  (w_pix_in),
      .o_dout (w_lb_dout[gi])
    );
  end

  assign w_c2[0] = w_lb_dout[r_wr_sel];
  assign w_c2[1] = w_lb_dout[~r_wr_sel];
  assign w_c2[2] = r_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix    <= '0;
      r_wr_sel <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_c0[i] <= '0;
        r_c1[i] <= '0;
      end
    end else if (w_accept) begin
      r_pix    <= w_pix_in;
      r_wr_sel <= w_y_cur[0];
      for (int i = 0; i < 3; i++) begin
        r_c0[i] <= r_c1[i];
        r_c1[i] <= w_c2[i];
      end
    end
  end

  for (gi = 0; gi < 3; gi++) begin : g_row
    assign w_tap[3*gi]     = r_c0[gi];
    assign w_tap[3*gi + 1] = r_c1[gi];
    assign w_tap[3*gi + 2] = w_c2[gi];
  end

  for (gi = 0; gi < WIN_TAPS; gi++) begin : g_pack
    assign w_pack_r[PIX_W*gi +: PIX_W] = w_tap[gi][3*PIX_W-1 -: PIX_W];
    assign w_pack_g[PIX_W*gi +: PIX_W] = w_tap[gi][2*PIX_W-1 -: PIX_W];
    assign w_pack_b[PIX_W*gi +: PIX_W] = w_tap[gi][PIX_W-1 -: PIX_W];
  end

  // Taps move on every accept, so the last emitted window is latched for the gaps.
  assign w_win_r = r_win_valid ? w_pack_r : r_hold_r;
  assign w_win_g = r_win_valid ? w_pack_g : r_hold_g;
  assign w_win_b = r_win_valid ? w_pack_b : r_hold_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_hold_r     <= '0;
      r_hold_g     <= '0;
      r_hold_b     <= '0;
    end else begin
      r_win_valid  <= w_emit;
      r_win_last   <= w_emit && w_last_px;
      r_frame_done <= w_accept && w_last_px;
      if (r_win_valid) begin
        r_hold_r <= w_pack_r;
        r_hold_g <= w_pack_g;
        r_hold_b <= w_pack_b;
      end
    end
  end

`ifdef DEHAZE_WIN_OUT_REG_EN
  logic             r_o_valid, r_o_last, r_o_done;
  logic [WIN_W-1:0] r_o_r, r_o_g, r_o_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_done  <= 1'b0;
      r_o_r     <= '0;
      r_o_g     <= '0;
      r_o_b     <= '0;
    end else begin
      r_o_valid <= r_win_valid;
      r_o_last  <= r_win_last;
      r_o_done  <= r_frame_done;
      r_o_r     <= w_win_r;
      r_o_g     <= w_win_g;
      r_o_b     <= w_win_b;
    end
  end

  assign bus.win_valid  = r_o_valid;
  assign bus.win_last   = r_o_last;
  assign bus.frame_done = r_o_done;
  assign bus.win_r      = r_o_r;
  assign bus.win_g      = r_o_g;
  assign bus.win_b      = r_o_b;
`else
  assign bus.win_valid  = r_win_valid;
  assign bus.win_last   = r_win_last;
  assign bus.frame_done = r_frame_done;
  assign bus.win_r      = w_win_r;
  assign bus.win_g      = w_win_g;
  assign bus.win_b      = w_win_b;
`endif

endmodule
